fifo_sync_circular: RTL and testbench
=====================================

// Module: fifo_sync_circular
// PURPOSE
// - Single-clock circular FIFO; parametrised successor of the async circular FIFO.
// - Adds the following:
//   - any depth >= 2 (power of two not required)
//   - occupancy count
//   - programmable almost-full/almost-empty flags
//   - standard or first-word-fall-through (FWFT) read mode
//   - sticky overflow/underflow flags and a synchronous clear
// - Sits between same-clock producer/consumer stages (UART, SPI datapaths).
// PARAMETERS
// DATA_WIDTH     8  width of one entry
// DATA_DEPTH     8  number of entries, >= 2
// AFULL_LEVEL    6  almost_full_out asserted when count >= AFULL_LEVEL
// AEMPTY_LEVEL   2  almost_empty_out asserted when count <= AEMPTY_LEVEL
// FWFT           0  0 = standard registered read, 1 = first-word-fall-through
// PORTS
// clk               in   1             single clock, rising edge
// nrst_in           in   1             asynchronous active-low reset
// clear_in          in   1             synchronous flush, empties FIFO
// data_write_in     in   DATA_WIDTH    write data
// write_en_in       in   1             write request
// read_en_in        in   1             read request / pop
// data_read_out     out  DATA_WIDTH    read data
// read_valid_out    out  1             data_read_out valid (see BEHAVIOUR)
// writable_out      out  1             not full and out of reset
// readable_out      out  1             not empty
// almost_full_out   out  1             count >= AFULL_LEVEL
// almost_empty_out  out  1             count <= AEMPTY_LEVEL
// count_out         out  CW            entries held; CW = $clog2(DATA_DEPTH+1)
// overflow_out      out  1             sticky: write attempted while !writable_out
// underflow_out     out  1             sticky: read attempted while !readable_out
// BEHAVIOUR
// Reset (nrst_in low, async)
// - pointers, count, data_read_out, read_valid_out, sticky flags = 0
// - writable_out = 0, readable_out = 0, almost_full_out = 0, almost_empty_out = 1
// - Internal ready bit sets on the first clk edge after release; writable_out goes 1 on that edge.
// Accept rules (evaluated at posedge)
// - wr_acc = write_en_in & writable_out; rd_acc = read_en_in & readable_out.
// - Full: writes are dropped even if a read is accepted the same cycle; no pass-through.
// - Empty: reads are dropped, even with a same-cycle write.
// - wr_acc: mem[wptr] <= data; wptr <= (wptr == DATA_DEPTH-1) ? 0 : wptr+1. rd_acc: rptr likewise.
// - count_out: +1 on wr_acc only, -1 on rd_acc only, unchanged on both/neither.
// - Flags are registered from the next count, so all update on the same edge as count_out.
// - readable_out = (count != 0); writable_out = ready & (count != DATA_DEPTH).
// - Ambiguity when pointers are equal is resolved by count_out.
// Read modes
// - FWFT=0:
//   - data_read_out <= mem[rptr] on the rd_acc edge; read_valid_out pulses 1 on that edge for 1 cycle.
//   - Latency is 1 cycle.
//   - data_read_out holds its value otherwise.
// - FWFT=1:
//   - data_read_out = mem[rptr] combinationally; read_valid_out = readable_out.
//   - rd_acc pops the shown word.
//   - The first write to an empty FIFO is visible the cycle after its edge.
// Sticky flags
// - overflow_out <= 1 on write_en_in & !writable_out.
// - underflow_out <= 1 on read_en_in & !readable_out.
// - Cleared only by reset or clear_in.
// clear_in
// - Pointers, count and sticky flags <= 0; read_valid_out <= 0.
// - Overrides a same-cycle write/read: nothing is stored or popped.
// - Memory contents are not cleared.
// Write data is never read from an unwritten slot; memory has no reset.
// STRUCTURE
// - fifo_pkg.vh (shared include): FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1, and a
//   `FIFO_CW(depth) macro = $clog2(depth+1); reused by later FIFO variants.
// - Sub-module fifo_ptr_wrap #(DATA_DEPTH): registered pointer with inc_in, clr_in and
//   wrap at DATA_DEPTH-1. Two instances, write and read.
// - Top level holds the memory array, count register, flag logic and read-mode generate block.
// TESTING (both FWFT values; DATA_DEPTH = 8 and 5)
// 1. Reset then idle
//    - writable_out 0 in reset, 1 on first edge after release
//    - readable_out 0, almost_empty_out 1, count_out 0
// 2. Fill then drain
//    - Write 0x01..0x08 at depth 8: almost_full_out 1 at count 6, writable_out 0 at count 8.
//    - 9th write 0xAA dropped, overflow_out 1.
//    - Drain yields 0x01..0x08 in order; FWFT=0 data appears 1 cycle after read_en_in.
// 3. Wrap-around at depth 5
//    - 3 writes, 3 reads, then 5 writes 0x10..0x14: pointers wrap 4 -> 0.
//    - Readout is 0x10..0x14 and count_out returns to 0.
// 4. Simultaneous ops
//    - count 3 with write and read same cycle: count stays 3, order preserved.
//    - Empty with both: only write taken, count 1, underflow_out 1.
//    - Full with both: only read taken, count 7.
// 5. clear_in mid-stream
//    - count 4 with write_en_in during clear_in: count 0, readable_out 0, sticky flags 0.
//    - Next write 0x55 reads back 0x55.
// 6. Async reset mid-operation
//    - nrst_in low between edges at count 5: all outputs take reset values immediately.
//    - After release, behaves as scenario 1.

Source files
------------

// File: rtl/fifo_sync_circular_pkg.sv
// Shared definitions for the synchronous FIFO family.
// - FIFO_MODE_STD / FIFO_MODE_FWFT select the read mode.
// - fifo_cw(depth): width of an occupancy counter able to hold 0..depth.
// - fifo_pw(depth): width of a pointer addressing 0..depth-1.
package fifo_sync_circular_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  function automatic int unsigned fifo_cw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned fifo_pw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync_circular_ptr_wrap.sv
// Registered FIFO pointer that wraps at DATA_DEPTH-1 (any depth >= 2).
// Ports:
//   clk      rising-edge clock
//   nrst_in  asynchronous active-low reset, pointer -> 0
//   inc_in   advance pointer by one (wrapping)
//   clr_in   synchronous clear to 0, has priority over inc_in
//   ptr_out  current pointer value
module fifo_sync_circular_ptr_wrap
  import fifo_sync_circular_pkg::*;
#(
  parameter  int unsigned DATA_DEPTH = 8,
  localparam int unsigned PW         = fifo_pw(DATA_DEPTH)
) (
  input  logic          clk,
  input  logic          nrst_in,
  input  logic          inc_in,
  input  logic          clr_in,
  output logic [PW-1:0] ptr_out
);

  localparam logic [PW-1:0] LAST = PW'(DATA_DEPTH - 1);

  // Pointer register with explicit wrap so non-power-of-two depths work
  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      ptr_out <= '0;
    end else if (clr_in) begin
      ptr_out <= '0;
    end else if (inc_in) begin
      ptr_out <= (ptr_out == LAST) ? '0 : ptr_out + PW'(1);
    end
  end

endmodule

// File: rtl/fifo_sync_circular.sv
// Single-clock circular FIFO with occupancy count, programmable almost
// flags, standard or first-word-fall-through read, sticky error flags and
// a synchronous clear.
// Ports:
//   clk, nrst_in                  clock / async active-low reset
//   clear_in                      synchronous flush (pointers, count, stickies)
//   data_write_in, write_en_in    write side
//   read_en_in                    read request / pop
//   data_read_out, read_valid_out read data and its qualifier
//   writable_out, readable_out    not full (and out of reset) / not empty
//   almost_full_out               count >= AFULL_LEVEL
//   almost_empty_out              count <= AEMPTY_LEVEL
//   count_out                     entries held
//   overflow_out, underflow_out   sticky: rejected write / rejected read
module fifo_sync_circular
  import fifo_sync_circular_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH   = 8,
  parameter  int unsigned DATA_DEPTH   = 8,
  parameter  int unsigned AFULL_LEVEL  = 6,
  parameter  int unsigned AEMPTY_LEVEL = 2,
  parameter  int unsigned FWFT         = 0,
  localparam int unsigned CW           = fifo_cw(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  nrst_in,
  input  logic                  clear_in,
  input  logic [DATA_WIDTH-1:0] data_write_in,
  input  logic                  write_en_in,
  input  logic                  read_en_in,
  output logic [DATA_WIDTH-1:0] data_read_out,
  output logic                  read_valid_out,
  output logic                  writable_out,
  output logic                  readable_out,
  output logic                  almost_full_out,
  output logic                  almost_empty_out,
  output logic [CW-1:0]         count_out,
  output logic                  overflow_out,
  output logic                  underflow_out
);

  localparam int unsigned   PW       = fifo_pw(DATA_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DATA_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [CW-1:0]         count_nxt;

  // Accept decisions and next occupancy; clear overrides any same-cycle op
  always_comb begin
    wr_acc    = write_en_in & writable_out & ~clear_in;
    rd_acc    = read_en_in & readable_out & ~clear_in;
    count_nxt = count_out;
    if (clear_in) begin
      count_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      count_nxt = count_out + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count_out - CW'(1);
    end
  end

  // Count and status flags, all derived from the next count so they move together.
  // Any clocked cycle out of reset means the FIFO is ready, so writable_out
  // only has to look at fullness here.
  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      count_out        <= '0;
      writable_out     <= 1'b0;
      readable_out     <= 1'b0;
      almost_full_out  <= 1'b0;
      almost_empty_out <= 1'b1;
      overflow_out     <= 1'b0;
      underflow_out    <= 1'b0;
    end else begin
      count_out        <= count_nxt;
      writable_out     <= (count_nxt != DEPTH_C);
      readable_out     <= (count_nxt != '0);
      almost_full_out  <= (count_nxt >= AFULL_C);
      almost_empty_out <= (count_nxt <= AEMPTY_C);
      if (clear_in) begin
        overflow_out  <= 1'b0;
        underflow_out <= 1'b0;
      end else begin
        overflow_out  <= overflow_out | (write_en_in & ~writable_out);
        underflow_out <= underflow_out | (read_en_in & ~readable_out);
      end
    end
  end

  fifo_sync_circular_ptr_wrap #(.DATA_DEPTH(DATA_DEPTH)) u_wptr (
    .clk     (clk),
    .nrst_in (nrst_in),
    .inc_in  (wr_acc),
    .clr_in  (clear_in),
    .ptr_out (wptr)
  );

  fifo_sync_circular_ptr_wrap #(.DATA_DEPTH(DATA_DEPTH)) u_rptr (
    .clk     (clk),
    .nrst_in (nrst_in),
    .inc_in  (rd_acc),
    .clr_in  (clear_in),
    .ptr_out (rptr)
  );

  // Storage; deliberately not reset and not cleared
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= data_write_in;
    end
  end

  // Read-side presentation
  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign data_read_out  = mem[rptr];
    assign read_valid_out = readable_out;
  end else begin : g_std
    always_ff @(posedge clk or negedge nrst_in) begin
      if (!nrst_in) begin
        data_read_out  <= '0;
        read_valid_out <= 1'b0;
      end else begin
        read_valid_out <= rd_acc;
        if (rd_acc) begin
          data_read_out <= mem[rptr];
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_circular.sv
// Self-checking bench: four FIFO instances (depth 8/5, standard/FWFT) share
// one stimulus stream; a queue-based model checks every instance on each
// falling edge, and literal expectations pin key points of each scenario.
module tb_fifo_sync_circular;

  localparam int NI = 4;
  localparam int DEP [NI] = '{8, 8, 5, 5};
  localparam int FW  [NI] = '{0, 1, 0, 1};
  localparam int AF  [NI] = '{6, 6, 4, 4};
  localparam int AE  [NI] = '{2, 2, 1, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       wen;
  logic       ren;
  logic [7:0] wdata;

  always #5 clk = ~clk;

  wire [7:0] d_data [NI];
  wire       d_rv   [NI];
  wire       d_wr   [NI];
  wire       d_rd   [NI];
  wire       d_af   [NI];
  wire       d_ae   [NI];
  wire       d_ov   [NI];
  wire       d_un   [NI];
  wire [3:0] d_cnt  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned CWG = $clog2(DEP[g] + 1);
    wire [CWG-1:0] cnt;
    fifo_sync_circular #(
      .DATA_WIDTH   (8),
      .DATA_DEPTH   (DEP[g]),
      .AFULL_LEVEL  (AF[g]),
      .AEMPTY_LEVEL (AE[g]),
      .FWFT         (FW[g])
    ) u_dut (
      .clk              (clk),
      .nrst_in          (rst_n),
      .clear_in         (clr),
      .data_write_in    (wdata),
      .write_en_in      (wen),
      .read_en_in       (ren),
      .data_read_out    (d_data[g]),
      .read_valid_out   (d_rv[g]),
      .writable_out     (d_wr[g]),
      .readable_out     (d_rd[g]),
      .almost_full_out  (d_af[g]),
      .almost_empty_out (d_ae[g]),
      .count_out        (cnt),
      .overflow_out     (d_ov[g]),
      .underflow_out    (d_un[g])
    );
    assign d_cnt[g] = 4'(cnt);
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int inst, input int act, input int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d] t=%0t: got %0h, expected %0h", name, inst, $time, act, exp);
  endtask

  // Behavioural model: one queue per instance plus sticky/ready bits
  logic [7:0] mq    [NI][$];
  bit         m_rdy [NI];
  bit         m_ov  [NI];
  bit         m_un  [NI];
  bit         m_rv  [NI];
  logic [7:0] m_rd  [NI];
  bit         can_w;
  bit         can_r;

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        m_rdy[i] = 0; m_ov[i] = 0; m_un[i] = 0; m_rv[i] = 0; m_rd[i] = 8'h00;
      end else begin
        can_w = m_rdy[i] && (mq[i].size() < DEP[i]);
        can_r = (mq[i].size() > 0);
        if (clr) begin
          mq[i].delete();
          m_ov[i] = 0; m_un[i] = 0; m_rv[i] = 0;
        end else begin
          if (wen && !can_w) m_ov[i] = 1;
          if (ren && !can_r) m_un[i] = 1;
          m_rv[i] = ren && can_r;
          if (ren && can_r) m_rd[i] = mq[i].pop_front();
          if (wen && can_w) mq[i].push_back(wdata);
        end
        m_rdy[i] = 1;
      end
    end
  end

  // Compare every instance against the model on each falling edge
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int n;
      n = mq[i].size();
      chk("count", i, int'(d_cnt[i]), n);
      chk("writable", i, int'(d_wr[i]), int'(m_rdy[i] && n < DEP[i]));
      chk("readable", i, int'(d_rd[i]), int'(n > 0));
      chk("almost_full", i, int'(d_af[i]), int'(n >= AF[i]));
      chk("almost_empty", i, int'(d_ae[i]), int'(n <= AE[i]));
      chk("overflow", i, int'(d_ov[i]), int'(m_ov[i]));
      chk("underflow", i, int'(d_un[i]), int'(m_un[i]));
      if (FW[i] == 0) begin
        chk("rd_valid", i, int'(d_rv[i]), int'(m_rv[i]));
        chk("rd_data", i, int'(d_data[i]), int'(m_rd[i]));
      end else begin
        chk("rd_valid", i, int'(d_rv[i]), int'(n > 0));
        if (n > 0) chk("rd_data", i, int'(d_data[i]), int'(mq[i][0]));
      end
    end
  end

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    wen = w; ren = r; clr = c; wdata = d;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; clr = 1'b0; wen = 1'b0; ren = 1'b0; wdata = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    // 1. reset then idle
    chk("lit_rst_writable", 0, int'(d_wr[0]), 0);
    chk("lit_rst_aempty", 1, int'(d_ae[1]), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("lit_release_writable", 2, int'(d_wr[2]), 0);
    @(posedge clk); #1;
    chk("lit_first_edge_writable", 0, int'(d_wr[0]), 1);
    chk("lit_idle_count", 3, int'(d_cnt[3]), 0);
    chk("lit_idle_readable", 0, int'(d_rd[0]), 0);

    // 2. fill then drain
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 1'b0, 1'b0, (k == 9) ? 8'hAA : 8'(k));
      if (k == 5) begin
        chk("lit_af_at5", 0, int'(d_af[0]), 0);
        chk("lit_d5_full_wr", 2, int'(d_wr[2]), 0);
        chk("lit_d5_full_cnt", 2, int'(d_cnt[2]), 5);
      end
      if (k == 6) begin
        chk("lit_af_at6", 0, int'(d_af[0]), 1);
        chk("lit_cnt6", 0, int'(d_cnt[0]), 6);
      end
    end
    chk("lit_full_cnt", 0, int'(d_cnt[0]), 8);
    chk("lit_full_wr", 0, int'(d_wr[0]), 0);
    chk("lit_overflow", 0, int'(d_ov[0]), 1);
    chk("lit_fwft_head", 1, int'(d_data[1]), 8'h01);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      if (k <= 2) chk("lit_drain_data", 0, int'(d_data[0]), k);
    end
    chk("lit_drain_rv", 0, int'(d_rv[0]), 1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("lit_idle_rv", 0, int'(d_rv[0]), 0);
    chk("lit_hold_data", 0, int'(d_data[0]), 8'h08);
    chk("lit_no_underflow", 0, int'(d_un[0]), 0);
    chk("lit_d5_underflow", 2, int'(d_un[2]), 1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("lit_clr_ov", 0, int'(d_ov[0]), 0);

    // 3. wrap-around
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 8'h20 + 8'(k));
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 8'h10 + 8'(k));
    chk("lit_wrap_cnt", 2, int'(d_cnt[2]), 5);
    for (int k = 0; k < 5; k++) begin
      chk("lit_wrap_fwft", 3, int'(d_data[3]), 8'h10 + k);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("lit_wrap_std", 2, int'(d_data[2]), 8'h10 + k);
    end
    chk("lit_wrap_cnt0", 2, int'(d_cnt[2]), 0);

    // 4. simultaneous operations
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 8'h30 + 8'(k));
    step(1'b1, 1'b1, 1'b0, 8'h33);
    chk("lit_both_cnt", 0, int'(d_cnt[0]), 3);
    chk("lit_both_data", 0, int'(d_data[0]), 8'h30);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h40);
    chk("lit_empty_both_cnt", 0, int'(d_cnt[0]), 1);
    chk("lit_empty_both_un", 0, int'(d_un[0]), 1);
    chk("lit_empty_both_rv", 0, int'(d_rv[0]), 0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 8'h50 + 8'(k));
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    chk("lit_full_both_cnt", 0, int'(d_cnt[0]), 7);
    chk("lit_full_both_data", 0, int'(d_data[0]), 8'h50);
    chk("lit_full_both_d5", 2, int'(d_cnt[2]), 4);

    // 5. clear mid-stream
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("lit_pre_clr_cnt", 0, int'(d_cnt[0]), 4);
    chk("lit_pre_clr_ov", 0, int'(d_ov[0]), 1);
    step(1'b1, 1'b0, 1'b1, 8'h99);
    chk("lit_clr_cnt", 0, int'(d_cnt[0]), 0);
    chk("lit_clr_rd", 1, int'(d_rd[1]), 0);
    chk("lit_clr_ov2", 0, int'(d_ov[0]), 0);
    step(1'b1, 1'b0, 1'b0, 8'h55);
    chk("lit_post_clr_fwft", 1, int'(d_data[1]), 8'h55);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("lit_post_clr_std", 0, int'(d_data[0]), 8'h55);

    // 6. async reset mid-operation
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 8'h70 + 8'(k));
    chk("lit_pre_rst_cnt", 0, int'(d_cnt[0]), 5);
    chk("lit_pre_rst_af", 2, int'(d_af[2]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_arst_cnt", 0, int'(d_cnt[0]), 0);
    chk("lit_arst_wr", 0, int'(d_wr[0]), 0);
    chk("lit_arst_rd", 1, int'(d_rd[1]), 0);
    chk("lit_arst_rv", 1, int'(d_rv[1]), 0);
    chk("lit_arst_ae", 2, int'(d_ae[2]), 1);
    chk("lit_arst_af", 2, int'(d_af[2]), 0);
    chk("lit_arst_data", 0, int'(d_data[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("lit_rel_wr", 0, int'(d_wr[0]), 0);
    @(posedge clk); #1;
    chk("lit_rel_wr_edge", 0, int'(d_wr[0]), 1);
    step(1'b1, 1'b0, 1'b0, 8'h77);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("lit_rel_data", 0, int'(d_data[0]), 8'h77);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
